sqrt: RTL and testbench

//  Pipelined IEEE-754 binary32 square root for the FPU datapath.

---
 rtl/fpu_pkg.sv | 46 ++++
 rtl/sqrt_table.sv | 43 ++++
 rtl/sqrt.sv | 107 ++++++++++
 tb/tb_sqrt.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared binary32 types and constants for the FPU datapath.
// isqrt64 is an elaboration-time helper used to build root tables.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF  = 32'h7F80_0000;
    localparam int          EXP_BIAS = 127;

    localparam logic [1:0] SPEC_NONE = 2'd0;
    localparam logic [1:0] SPEC_PINF = 2'd1;
    localparam logic [1:0] SPEC_QNAN = 2'd2;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic       zero;
        logic [1:0] spec;
    } sqrt_ctl_t;

    // Floor square root of a 64-bit integer, bit-pair restoring method.
    function automatic logic [31:0] isqrt64(input logic [63:0] v);
        logic [63:0] op;
        logic [63:0] res;
        logic [63:0] one;
        op  = v;
        res = 64'd0;
        one = 64'h4000_0000_0000_0000;
        for (int i = 0; i < 32; i++) begin
            if (op >= res + one) begin
                op  = op - (res + one);
                res = (res >> 1) + one;
            end else begin
                res = res >> 1;
            end
            one = one >> 2;
        end
        return res[31:0];
    endfunction

endpackage

// File: rtl/sqrt_table.sv
// Combinational 1024-entry root ROM: index {e[0], man[22:14]} -> chord {intercept, slope}.
// Values are Q1.30 roots of the segment endpoints, computed at elaboration.
module sqrt_table
    import fpu_pkg::*;
(
    input  logic [9:0]  i_idx,
    output logic [31:0] o_intercept,
    output logic [21:0] o_slope
);

    // idx[9]=1 (odd biased exponent): significand in [1,2), segment width 2^-9.
    // idx[9]=0: significand doubled into [2,4), segment width 2^-8.
    function automatic logic [53:0] rom_entry(input int idx);
        logic [63:0] base;
        logic [63:0] n0;
        logic [63:0] n1;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] d;
        base = 64'(512 + (idx % 512));
        if (idx >= 512) begin
            n0 = base << 51;
            n1 = (base + 64'd1) << 51;
        end else begin
            n0 = base << 52;
            n1 = (base + 64'd1) << 52;
        end
        r0 = isqrt64(n0);
        r1 = isqrt64(n1);
        d  = r1 - r0;
        return {r0, d[21:0]};
    endfunction

    logic [53:0] w_rom [1024];

    for (genvar g = 0; g < 1024; g++) begin : g_rom
        localparam logic [53:0] ENTRY = rom_entry(g);
        assign w_rom[g] = ENTRY;
    end

    assign {o_intercept, o_slope} = w_rom[i_idx];

endmodule

// File: rtl/sqrt.sv
// sqrt: 5-stage pipelined binary32 square root, one operand per cycle, no stall.
// Define SQRT_SPECIAL_EN for IEEE handling of +inf, NaN and negative operands.
module sqrt
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    output logic [31:0] y,
    input  logic        clk,
    input  logic        rstn
);

    fp32_t       w_x;
    logic [8:0]  w_esum;
    logic [1:0]  w_spec;
    logic [31:0] w_icpt;
    logic [21:0] w_slope;
    logic [35:0] w_prod;
    logic [31:0] w_rnd;
    logic [22:0] w_man;
    logic        w_unused;

    sqrt_ctl_t   r1_ctl, r2_ctl, r3_ctl, r4_ctl;
    logic [9:0]  r1_idx;
    logic [13:0] r1_frac, r2_frac;
    logic [31:0] r2_icpt, r3_icpt, r4_root;
    logic [21:0] r2_slope, r3_prod;
    logic [31:0] r_y;

    assign w_x    = x1;
    assign w_esum = {1'b0, w_x.exp} + 9'(EXP_BIAS);

`ifdef SQRT_SPECIAL_EN
    always_comb begin
        w_spec = SPEC_NONE;
        if (w_x.exp == 8'hFF && w_x.man != 23'd0)
            w_spec = SPEC_QNAN;
        else if (w_x.sign && w_x.exp != 8'd0)
            w_spec = SPEC_QNAN;
        else if (w_x.exp == 8'hFF)
            w_spec = SPEC_PINF;
    end
`else
    assign w_spec = SPEC_NONE;
`endif

    sqrt_table u_table (
        .i_idx       (r1_idx),
        .o_intercept (w_icpt),
        .o_slope     (w_slope)
    );

    assign w_prod = {14'd0, r2_slope} * {22'd0, r2_frac};

    // Chord lies below the true root, so rounding up never exceeds 2.0 except
    // at the very top segment; saturate there instead of bumping the exponent.
    assign w_rnd = r4_root + 32'd64;
    assign w_man = w_rnd[31] ? 23'h7F_FFFF : w_rnd[29:7];

    assign w_unused = ^{w_esum[0], w_prod[13:0], w_rnd[30], w_rnd[6:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r1_ctl   <= '0;
            r1_idx   <= '0;
            r1_frac  <= '0;
            r2_ctl   <= '0;
            r2_frac  <= '0;
            r2_icpt  <= '0;
            r2_slope <= '0;
            r3_ctl   <= '0;
            r3_icpt  <= '0;
            r3_prod  <= '0;
            r4_ctl   <= '0;
            r4_root  <= '0;
            r_y      <= '0;
        end else begin
            r1_ctl   <= '{sign: w_x.sign, exp: w_esum[8:1],
                          zero: (w_x.exp == 8'd0), spec: w_spec};
            r1_idx   <= {w_x.exp[0], w_x.man[22:14]};
            r1_frac  <= w_x.man[13:0];

            r2_ctl   <= r1_ctl;
            r2_frac  <= r1_frac;
            r2_icpt  <= w_icpt;
            r2_slope <= w_slope;

            r3_ctl   <= r2_ctl;
            r3_icpt  <= r2_icpt;
            r3_prod  <= w_prod[35:14];

            r4_ctl   <= r3_ctl;
            r4_root  <= r3_icpt + {10'd0, r3_prod};

            if (r4_ctl.spec == SPEC_PINF)
                r_y <= FP_PINF;
            else if (r4_ctl.spec == SPEC_QNAN)
                r_y <= FP_QNAN;
            else if (r4_ctl.zero)
                r_y <= {r4_ctl.sign, 31'd0};
            else
                r_y <= {1'b0, r4_ctl.exp, w_man};
        end
    end

    assign y = r_y;

endmodule

// File: tb/tb_sqrt.sv
// Scoreboard bench for sqrt: expected results queued at issue, compared when due 5 edges later.
// Honours SQRT_SPECIAL_EN for the special-operand cases.
module tb_sqrt;
    import fpu_pkg::*;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] x1   = 32'd0;
    logic [31:0] y;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] expv;
        int          tol;
        int          due;
        string       tag;
    } sb_t;

    sb_t sb_q[$];

    sqrt dut (
        .x1   (x1),
        .y    (y),
        .clk  (clk),
        .rstn (rstn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] expv, input int tol = 0);
        longint d;
        d = longint'(got) - longint'(expv);
        n_tests++;
        if (d > longint'(tol) || d < -longint'(tol)) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (tol %0d) at cycle %0d",
                     tag, got, expv, tol, cyc);
        end
    endtask

    // Independent reference: real-valued sqrt of the scaled significand, rounded to nearest.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
        logic [7:0] e;
        logic [8:0] es;
        real        s;
        real        q;
        int         mq;
        e = x[30:23];
        if (e == 8'd0) return {x[31], 31'd0};
`ifdef SQRT_SPECIAL_EN
        if (e == 8'hFF) return (x[22:0] != 23'd0 || x[31]) ? FP_QNAN : FP_PINF;
        if (x[31]) return FP_QNAN;
`endif
        s  = (1.0 + real'(x[22:0]) / 8388608.0) * (e[0] ? 1.0 : 2.0);
        q  = $sqrt(s);
        mq = $rtoi((q - 1.0) * 8388608.0 + 0.5);
        es = ({1'b0, e} + 9'd127) >> 1;
        return {1'b0, es[7:0], 23'd0} + 32'(mq);
    endfunction

    task automatic sb_check();
        sb_t e;
        if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            check_val(e.tag, y, e.expv, e.tol);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_check();
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] expv,
                         input int tol, input string tag);
        sb_t e;
        x1     = x;
        e.x    = x;
        e.expv = expv;
        e.tol  = tol;
        e.due  = cyc + 5;
        e.tag  = tag;
        sb_q.push_back(e);
        tick();
    endtask

    task automatic issue_rand_normal(input string tag);
        logic [31:0] x;
        x = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
        issue(x, ref_sqrt(x), 3, tag);
    endtask

    initial begin
        logic [31:0] x;
        rstn = 1'b0;
        x1   = 32'h4080_0000;
        repeat (3) @(negedge clk);
        check_val("reset_y", y, 32'h0);
        rstn = 1'b1;

        issue(32'h4080_0000, 32'h4000_0000, 0, "sqrt_4");
        issue(32'h3F80_0000, 32'h3F80_0000, 0, "sqrt_1");
        issue(32'h4000_0000, 32'h3FB5_04F3, 3, "sqrt_2");
        issue(32'h4040_0000, 32'h3FDD_B3D7, 3, "sqrt_3");
        issue(32'h0000_0000, 32'h0000_0000, 0, "zero");
        issue(32'h0040_0000, 32'h0000_0000, 0, "denorm");
        issue(32'h7F7F_FFFF, 32'h5F7F_FFFF, 3, "max_norm");
        issue(32'h8000_0000, 32'h8000_0000, 0, "neg_zero");
        issue(32'h0080_0000, 32'h2000_0000, 0, "min_norm");
`ifdef SQRT_SPECIAL_EN
        issue(32'h7F80_0000, 32'h7F80_0000, 0, "pos_inf");
        issue(32'h7FC1_2345, 32'h7FC0_0000, 0, "nan");
        issue(32'hC080_0000, 32'h7FC0_0000, 0, "neg_4");
        issue(32'hFF80_0000, 32'h7FC0_0000, 0, "neg_inf");
`else
        issue(32'hC080_0000, 32'h4000_0000, 0, "neg_4_abs");
        issue(32'hBF80_0000, 32'h3F80_0000, 0, "neg_1_abs");
`endif

        // Every table segment: both chord endpoints and one interior point.
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] e;
            e = i[9] ? 8'd127 : 8'd128;
            x = {1'b0, e, i[8:0], 14'd0};
            issue(x, ref_sqrt(x), 3, "seg_lo");
            x = {1'b0, e, i[8:0], 14'h3FFF};
            issue(x, ref_sqrt(x), 3, "seg_hi");
            x = {1'b0, e, i[8:0], 14'($urandom)};
            issue(x, ref_sqrt(x), 3, "seg_mid");
        end

        for (int i = 0; i < 300; i++) issue_rand_normal("rnd");

        // One-edge reset mid-stream discards everything in flight.
        rstn = 1'b0;
        sb_q.delete();
        x1 = 32'h4080_0000;
        tick();
        check_val("rst_mid_y", y, 32'h0);
        rstn = 1'b1;

        issue(32'h4080_0000, 32'h4000_0000, 0, "post_rst_4");
        issue(32'h3F80_0000, 32'h3F80_0000, 0, "post_rst_1");
        for (int i = 0; i < 200; i++) begin
            x = $urandom;
            if (x[30:23] == 8'hFF) x[30:23] = 8'hFE;
`ifdef SQRT_SPECIAL_EN
            if (i % 10 == 0) x[30:23] = 8'hFF;
`endif
            issue(x, ref_sqrt(x), 3, "mixed");
        end

        x1 = 32'd0;
        for (int i = 0; i < 12 && sb_q.size() != 0; i++) tick();
        check_val("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
